// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared constants, FSM state type and the request sanitiser
// for the H-bridge protection stage.
package hbridge_pkg;

  localparam logic [3:0] CODE_STOP  = 4'b0000;
  localparam logic [3:0] CODE_FWD   = 4'b1001;
  localparam logic [3:0] CODE_LEFT  = 4'b1010;
  localparam logic [3:0] CODE_RIGHT = 4'b0101;

  localparam logic [3:0] RAMP_LAST_LEVEL = 4'd8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_RAMP  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Only the four known bridge codes pass; anything else would short a leg
  // or is meaningless, so it collapses to stop.
  function automatic logic [3:0] sanitise(input logic [3:0] code);
    logic [3:0] res;
    case (code)
      CODE_FWD, CODE_LEFT, CODE_RIGHT: res = code;
      default:                         res = CODE_STOP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hbridge_guard_oc_sync2.sv
// oc_sync2: two-flop synchroniser for the asynchronous over-current input.
module oc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two-stage metastability filter, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/hbridge_guard.sv
// hbridge_guard: sanitises the steering direction code, inserts all-off
// dead-time on reversals and latches over-current faults before the bridge.
// Optional soft-start ramp is compiled in with the SOFT_START_EN macro.
module hbridge_guard
  import hbridge_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC  = 50_000,
  parameter int unsigned RAMP_STEP_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_req,
  input  logic [1:0] en_req,
  input  logic       oc,
  input  logic       fault_clr,
  output logic [3:0] IN,
  output logic [1:0] EN,
  output logic       fault,
  output logic       busy
);

  // One down-counter serves both dead-time and ramp steps.
  localparam int unsigned CNT_MAX = ((DEADTIME_CYC > RAMP_STEP_CYC) ? DEADTIME_CYC : RAMP_STEP_CYC) - 1;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       cur_code_q, cur_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic [3:0]       in_q, in_d;
  logic [1:0]       en_q, en_d;
  logic [3:0]       req_s;
  logic             oc_sync_s;

`ifdef SOFT_START_EN
  localparam logic [CNT_W-1:0] RAMP_LOAD = CNT_W'(RAMP_STEP_CYC - 1);
  logic [3:0] level_q, level_d;
  logic [2:0] pwm_cnt_q, pwm_cnt_d;
`endif

  oc_sync2 u_oc_sync (
    .clk (clk),
    .rst (rst),
    .d   (oc),
    .q   (oc_sync_s)
  );

  assign req_s = sanitise(in_req);

  // Next-state, counters and registered output values.
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
`ifdef SOFT_START_EN
    level_d    = level_q;
    pwm_cnt_d  = pwm_cnt_q + 3'd1;
`endif

    if (oc_sync_s) begin
      // Over-current beats every other transition.
      state_d = ST_FAULT;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_RAMP: begin
          if (req_s == cur_code_q) begin
`ifdef SOFT_START_EN
            if (state_q == ST_RAMP) begin
              if (cnt_q == CNT_ZERO) begin
                if (level_q == RAMP_LAST_LEVEL) begin
                  state_d = ST_RUN;
                end else begin
                  level_d = level_q + 4'd1;
                  cnt_d   = RAMP_LOAD;
                end
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end else begin
              state_d = ST_RUN;
            end
`else
            state_d = ST_RUN;
`endif
          end else if (req_s == CODE_STOP) begin
            // Stopping never needs dead-time.
            state_d    = ST_RUN;
            cur_code_d = CODE_STOP;
          end else if (cur_code_q == CODE_STOP) begin
            cur_code_d = req_s;
`ifdef SOFT_START_EN
            state_d = ST_RAMP;
            level_d = 4'd1;
            cnt_d   = RAMP_LOAD;
`else
            state_d = ST_RUN;
`endif
          end else begin
            // Reversal between two driving codes: all-off first.
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (cnt_q == CNT_ZERO) begin
            cur_code_d = req_s;
            if (req_s != CODE_STOP) begin
`ifdef SOFT_START_EN
              state_d = ST_RAMP;
              level_d = 4'd1;
              cnt_d   = RAMP_LOAD;
`else
              state_d = ST_RUN;
`endif
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state_d    = ST_RUN;
            cur_code_d = CODE_STOP;
            fault_d    = 1'b0;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d    = ST_RUN;
          cur_code_d = CODE_STOP;
        end
      endcase
    end

    // Outputs follow the state being entered so passthrough is one cycle.
    case (state_d)
      ST_RUN: begin
        in_d = cur_code_d;
        en_d = (cur_code_d == CODE_STOP) ? 2'b00 : en_req;
      end
      ST_RAMP: begin
        in_d = cur_code_d;
`ifdef SOFT_START_EN
        en_d = en_req & {2{({1'b0, pwm_cnt_q} < level_d)}};
`else
        en_d = 2'b00;
`endif
      end
      default: begin
        in_d = CODE_STOP;
        en_d = 2'b00;
      end
    endcase
    busy_d = (state_d == ST_DEAD) || (state_d == ST_RAMP);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cur_code_q <= CODE_STOP;
      cnt_q      <= CNT_ZERO;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_q       <= CODE_STOP;
      en_q       <= 2'b00;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
      in_q       <= in_d;
      en_q       <= en_d;
    end
  end

`ifdef SOFT_START_EN
  // Soft-start level and free-running PWM phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 4'd0;
      pwm_cnt_q <= 3'd0;
    end else begin
      level_q   <= level_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  assign IN    = in_q;
  assign EN    = en_q;
  assign fault = fault_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_hbridge_guard.sv
// tb_hbridge_guard: directed self-checking bench for hbridge_guard.
// Builds with or without SOFT_START_EN.
module tb_hbridge_guard;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_req;
  logic [1:0] en_req;
  logic       oc;
  logic       fault_clr;
  logic [3:0] IN;
  logic [1:0] EN;
  logic       fault;
  logic       busy;

  int checks   = 0;
  int failures = 0;

`ifdef SOFT_START_EN
  localparam logic RAMP_BUSY = 1'b1;
`else
  localparam logic RAMP_BUSY = 1'b0;
`endif

  hbridge_guard #(
    .DEADTIME_CYC  (4),
    .RAMP_STEP_CYC (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .en_req    (en_req),
    .oc        (oc),
    .fault_clr (fault_clr),
    .IN        (IN),
    .EN        (EN),
    .fault     (fault),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_req = 4'b0000; en_req = 2'b00; oc = 1'b0; fault_clr = 1'b0;
    tick(); tick();
    check_eq("rst_IN", {28'd0, IN}, 32'd0);
    check_eq("rst_EN", {30'd0, EN}, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);

    rst = 1'b0; in_req = 4'b1001; en_req = 2'b11;
    tick();
    check_eq("fwd_IN", {28'd0, IN}, 32'h9);
`ifdef SOFT_START_EN
    begin
      int hi;
      check_eq("ramp_busy", {31'd0, busy}, 32'd1);
      for (int lvl = 1; lvl <= 8; lvl++) begin
        hi = 0;
        for (int k = 0; k < 8; k++) begin
          if (k > 0 || lvl > 1) tick();
          if (EN == 2'b11) hi++;
        end
        check_eq($sformatf("ramp_duty_L%0d", lvl), hi, lvl);
      end
      check_eq("ramp_IN", {28'd0, IN}, 32'h9);
      tick();
      check_eq("ramp_done_EN", {30'd0, EN}, 32'h3);
      check_eq("ramp_done_busy", {31'd0, busy}, 32'd0);
    end
`else
    check_eq("fwd_EN", {30'd0, EN}, 32'h3);
    check_eq("fwd_busy", {31'd0, busy}, 32'd0);
`endif

    // Reversal 1001 -> 1010: four all-off cycles, then the new code.
    in_req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("dead%0d_IN", i), {28'd0, IN}, 32'd0);
      check_eq($sformatf("dead%0d_EN", i), {30'd0, EN}, 32'd0);
      check_eq($sformatf("dead%0d_busy", i), {31'd0, busy}, 32'd1);
    end
    tick();
    check_eq("after_dead_IN", {28'd0, IN}, 32'hA);
    check_eq("after_dead_busy", {31'd0, busy}, {31'd0, RAMP_BUSY});

    // Stop, then start 0101 without dead-time.
    in_req = 4'b0000;
    tick();
    check_eq("stop_IN", {28'd0, IN}, 32'd0);
    check_eq("stop_EN", {30'd0, EN}, 32'd0);
    check_eq("stop_busy", {31'd0, busy}, 32'd0);
    in_req = 4'b0101;
    tick();
    check_eq("right_IN", {28'd0, IN}, 32'h5);

    // Illegal code acts as stop immediately; re-request is immediate.
    in_req = 4'b1111;
    tick();
    check_eq("illegal_IN", {28'd0, IN}, 32'd0);
    check_eq("illegal_EN", {30'd0, EN}, 32'd0);
    check_eq("illegal_busy", {31'd0, busy}, 32'd0);
    in_req = 4'b0101;
    tick();
    check_eq("right2_IN", {28'd0, IN}, 32'h5);

    // Back to forward via stop.
    in_req = 4'b0000; tick();
    in_req = 4'b1001; tick();
    check_eq("fwd2_IN", {28'd0, IN}, 32'h9);

    // One-cycle oc pulse: zero by the 3rd edge, latched.
    oc = 1'b1; tick();
    oc = 1'b0; tick();
    check_eq("oc_e2_fault", {31'd0, fault}, 32'd0);
    tick();
    check_eq("oc_e3_IN", {28'd0, IN}, 32'd0);
    check_eq("oc_e3_EN", {30'd0, EN}, 32'd0);
    check_eq("oc_e3_fault", {31'd0, fault}, 32'd1);
    tick(); tick(); tick();
    check_eq("oc_latched", {31'd0, fault}, 32'd1);
    check_eq("oc_latched_IN", {28'd0, IN}, 32'd0);
    fault_clr = 1'b1; tick();
    check_eq("clr_fault", {31'd0, fault}, 32'd0);
    check_eq("clr_IN", {28'd0, IN}, 32'd0);
    fault_clr = 1'b0; tick();
    check_eq("post_clr_IN", {28'd0, IN}, 32'h9);

    // oc held with fault_clr held: stays in fault until oc clears through the synchroniser.
    oc = 1'b1; fault_clr = 1'b1;
    tick(); tick(); tick();
    check_eq("ochold_fault", {31'd0, fault}, 32'd1);
    tick(); tick();
    check_eq("ochold_fault2", {31'd0, fault}, 32'd1);
    oc = 1'b0;
    tick();
    check_eq("ocrel_a", {31'd0, fault}, 32'd1);
    tick();
    check_eq("ocrel_b", {31'd0, fault}, 32'd1);
    tick();
    check_eq("ocrel_c", {31'd0, fault}, 32'd0);
    fault_clr = 1'b0; tick();
    check_eq("ocrel_IN", {28'd0, IN}, 32'h9);

    // Reset in the middle of a dead-time.
    in_req = 4'b0101; tick();
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    tick();
    rst = 1'b1; tick();
    check_eq("rst_dead_IN", {28'd0, IN}, 32'd0);
    check_eq("rst_dead_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_dead_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0; in_req = 4'b1010; tick();
    check_eq("rst_then_IN", {28'd0, IN}, 32'hA);
    check_eq("rst_then_busy", {31'd0, busy}, {31'd0, RAMP_BUSY});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hbridge_guard.md
# hbridge_guard

Protection stage between the line-follow steering logic and the H-bridge pins. Takes the requested 4-bit bridge direction code and 2-bit PWM enables, sanitises the code, and inserts an all-off dead-time whenever the bridge reverses between two non-stop codes. It latches an over-current fault that forces the bridge off until explicitly cleared. An optional soft-start ramp can be compiled in.

## Interface
- DEADTIME_CYC, 50_000, all-off cycles between two different non-stop codes (0.5 ms at 100 MHz); minimum 1
- RAMP_STEP_CYC, 1_000_000, cycles held at each soft-start duty level (only used with SOFT_START_EN)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_req  in  4  requested direction code from steering stage
- en_req  in  2  requested enables (PWM speed pulse, gated by run switch upstream)
- oc  in  1  over-current comparator, active-high, asynchronous to clk
- fault_clr  in  1  level; clears latched fault
- IN  out  4  direction code to bridge, registered
- EN  out  2  enables to bridge, registered
- fault  out  1  latched over-current indication
- busy  out  1  high in DEAD or RAMP

## Operation
- Legal codes: 0000 stop, 1001 forward, 1010 left, 0101 right. Any other in_req value is treated as 0000.
- States: RUN, DEAD, RAMP (only with SOFT_START_EN), FAULT. Internal cur_code, 4 bits.
- Reset: state RUN, cur_code 0000, IN 0000, EN 00, fault 0, busy 0, counters 0.
- RUN: IN = cur_code, EN = en_req (EN forced 00 while cur_code = 0000).
  - Sanitised request = cur_code: no change.
  - Request = 0000: cur_code <= 0000 at once, no dead-time.
  - cur_code = 0000 and request non-zero: cur_code <= request, then RAMP if compiled in, otherwise stay in RUN.
  - Both non-zero and different: go to DEAD and load the counter with DEADTIME_CYC-1.
- DEAD: IN 0000, EN 00. Counter decrements each cycle. At 0, sample the current sanitised request into cur_code; go to RAMP if compiled in and the sample is non-zero, otherwise RUN. Request changes during DEAD do not restart the counter. Sampling 0000 goes to RUN.
- FAULT: IN 0000, EN 00, fault 1. Exit only when fault_clr = 1 and synchronised oc = 0. Exit goes to RUN with cur_code 0000. fault deasserts on the same edge.
- Synchronised oc = 1 in any state forces FAULT on the next edge. This has priority over every other transition, including rst-free DEAD/RAMP expiry.
- rst has priority over everything and aborts DEAD, RAMP or FAULT mid-operation.

## Timing
- RUN passthrough latency: 1 cycle from in_req/en_req to IN/EN.
- oc uses a 2-flop synchroniser. IN/EN are zero no later than the 3rd rising edge after oc rises.
- Reversal: the first all-off cycle is the edge after the request change. Exactly DEADTIME_CYC all-off cycles. The new code appears on the following edge.
- The counter is wide enough for the larger of DEADTIME_CYC-1 and RAMP_STEP_CYC-1 (use $clog2). No wrap: it stops at 0.

## Configuration
- SOFT_START_EN defined: RAMP state present. An internal 3-bit PWM counter runs free. Duty level L steps 1..8 and holds RAMP_STEP_CYC cycles per step. EN = en_req & {2{pwm_cnt < L}}. IN = cur_code throughout. Leave to RUN after level 8 completes. A request change during RAMP follows the RUN rules: 0000 aborts to RUN, a different non-zero code goes to DEAD.
- Not defined: no RAMP state and no ramp counters. Transitions that would enter RAMP enter RUN instead. busy reflects DEAD only.

## Structure
- Package hbridge_pkg: code constants (CODE_STOP, CODE_FWD, CODE_LEFT, CODE_RIGHT), the state enum, and a sanitise function.
- One sub-module, oc_sync2: 2-flop synchroniser with synchronous reset to 0.

## Test plan
- Reset, then in_req 1001, en_req 11: IN = 1001 and EN = 11 one cycle later, busy 0.
- From 1001, in_req 1010 with DEADTIME_CYC = 4: exactly 4 cycles of IN 0000 / EN 00 with busy 1, then IN 1010.
- in_req 1111 while running 0101: IN 0000 next cycle with no dead-time. Then in_req 0101: IN 0101 with no dead-time.
- oc pulses high for 1 cycle during RUN 1001: IN/EN zero by the 3rd edge and fault 1. Stays latched with fault_clr 0. fault_clr 1 with oc 0 gives fault 0 and IN 0000.
- oc high while fault_clr held high: remains in FAULT. rst during DEAD: IN 0000, state RUN, cur_code 0000.
- With SOFT_START_EN, RAMP_STEP_CYC = 8, from stop to 1001 with en_req 11: EN duty measured as 1/8, 2/8 … 8/8 over successive 8-cycle windows, then steady 11.
